// File: rtl/q7_round_sat_fifo_pkg.sv
// Shared constants and the Q2.14 -> Q1.7 round-half-up/saturate helper used by
// the datapath and by the bench reference model.
package q7_pkg;

    localparam int Q_IN_W       = 16;
    localparam int Q_OUT_W      = 8;
    localparam int Q_FRAC_SHIFT = 7;
    localparam int OUT_MAX      = 127;
    localparam int OUT_MIN      = -128;
    localparam int ROUND_BIAS   = 64;

    typedef struct packed {
        logic [Q_OUT_W-1:0] r;
        logic               sat;
    } rs_t;

    // Bias is added one bit wider than the input so the sum can never wrap.
    function automatic rs_t round_sat(input logic [Q_IN_W-1:0] s);
        logic signed [Q_IN_W:0]                sum;
        logic signed [Q_IN_W-Q_FRAC_SHIFT:0]   q;
        rs_t                                   o;
        sum = $signed({s[Q_IN_W-1], s}) + $signed((Q_IN_W+1)'(ROUND_BIAS));
        q   = sum[Q_IN_W:Q_FRAC_SHIFT];
        if (int'(q) > OUT_MAX) begin
            o.r   = Q_OUT_W'(OUT_MAX);
            o.sat = 1'b1;
        end else if (int'(q) < OUT_MIN) begin
            o.r   = Q_OUT_W'(OUT_MIN);
            o.sat = 1'b1;
        end else begin
            o.r   = q[Q_OUT_W-1:0];
            o.sat = 1'b0;
        end
        return o;
    endfunction

endpackage

// File: rtl/q7_round_sat_fifo_sync_fifo.sv
// Synchronous FIFO; a push while full is accepted only if a pop happens on the
// same edge, otherwise it is ignored and the caller counts it as a drop.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             wr_en, rd_en;

    always_comb begin
        full     = (level_q == LW'(DEPTH));
        empty    = (level_q == '0);
        wr_en    = push & (~full | pop);
        rd_en    = pop & ~empty;
        mem_d    = mem_q;
        if (wr_en)
            mem_d[wr_ptr_q] = wdata;
        // Pointers wrap for free since DEPTH is a power of two.
        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        rd_ptr_d = rd_ptr_q + AW'(rd_en);
        level_d  = level_q + LW'(wr_en) - LW'(rd_en);
        rdata    = empty ? '0 : mem_q[rd_ptr_q];
        level    = level_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/q7_round_sat_fifo.sv
// Rounds/saturates upstream Q2.14 sums to Q1.7, buffers them in a FIFO and
// keeps sticky overflow plus saturating drop/saturation counters.
module q7_round_sat_fifo
    import q7_pkg::*;
#(
    parameter int IN_W       = Q_IN_W,
    parameter int OUT_W      = Q_OUT_W,
    parameter int FRAC_SHIFT = Q_FRAC_SHIFT,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = 8,
    localparam int LW        = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  s_in,
    input  logic             val_in,
    output logic [OUT_W-1:0] dout,
    output logic             dout_val,
    input  logic             dout_rdy,
    input  logic             clr_flags,
    output logic             ovf_flag,
    output logic [CNT_W-1:0] sat_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [LW-1:0]    level
);

    rs_t              rs;
    logic             st_vld_q, st_vld_d, st_sat_q, st_sat_d;
    logic [OUT_W-1:0] st_r_q, st_r_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d, drop_cnt_q, drop_cnt_d;
    logic             full, empty, pop, drop, sat_evt;

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(OUT_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (st_vld_q),
        .pop   (pop),
        .wdata (st_r_q),
        .rdata (dout),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_comb begin
        rs         = round_sat(s_in);
        st_vld_d   = val_in;
        st_r_d     = rs.r;
        st_sat_d   = rs.sat;
        dout_val   = ~empty;
        pop        = dout_val & dout_rdy;
        drop       = st_vld_q & full & ~pop;
        // Saturated samples count even when the FIFO drops them.
        sat_evt    = st_vld_q & st_sat_q;
        ovf_d      = ovf_q | drop;
        sat_cnt_d  = (sat_evt && sat_cnt_q != '1) ? sat_cnt_q + 1'b1 : sat_cnt_q;
        drop_cnt_d = (drop && drop_cnt_q != '1) ? drop_cnt_q + 1'b1 : drop_cnt_q;
        if (clr_flags) begin
            ovf_d      = 1'b0;
            sat_cnt_d  = '0;
            drop_cnt_d = '0;
        end
        ovf_flag   = ovf_q;
        sat_cnt    = sat_cnt_q;
        drop_cnt   = drop_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_vld_q   <= 1'b0;
            st_sat_q   <= 1'b0;
            st_r_q     <= '0;
            ovf_q      <= 1'b0;
            sat_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            st_vld_q   <= st_vld_d;
            st_sat_q   <= st_sat_d;
            st_r_q     <= st_r_d;
            ovf_q      <= ovf_d;
            sat_cnt_q  <= sat_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule
